// File: rtl/sprite_pkg.sv
// Shared screen geometry and state/mode encodings for the sprite drawing engine.
package sprite_pkg;

  localparam int SCREEN_W  = 320;
  localparam int SCREEN_H  = 240;
  localparam int BG_ADDR_W = 17;

  typedef enum logic [1:0] {IDLE, SCAN, FLUSH, DONE} state_t;
  typedef enum logic {MODE_BG, MODE_CHAR} mode_t;

endpackage

// File: rtl/sprite_scan_counter.sv
// Row-major cx/cy scan counter over a SPRITE_W x SPRITE_H box, with a last-pixel flag.
module sprite_scan_counter #(
  parameter int SPRITE_W = 8,
  parameter int SPRITE_H = 8
) (
  input  logic                        clock,
  input  logic                        resetn,
  input  logic                        clear,
  input  logic                        enable,
  output logic [$clog2(SPRITE_W)-1:0] cx,
  output logic [$clog2(SPRITE_H)-1:0] cy,
  output logic                        last
);

  localparam int CX_W = $clog2(SPRITE_W);
  localparam int CY_W = $clog2(SPRITE_H);
  localparam logic [CX_W-1:0] CX_MAX = CX_W'(SPRITE_W - 1);
  localparam logic [CY_W-1:0] CY_MAX = CY_W'(SPRITE_H - 1);

  always_ff @(posedge clock) begin
    if (!resetn || clear) begin
      cx <= '0;
      cy <= '0;
    end else if (enable) begin
      if (cx == CX_MAX) begin
        cx <= '0;
        cy <= cy + 1'b1;  // power-of-2 height wraps cy back to 0 after the last row
      end else begin
        cx <= cx + 1'b1;
      end
    end
  end

  assign last = (cx == CX_MAX) && (cy == CY_MAX);

endmodule

// File: rtl/sprite_drawer.sv
// Sprite/background drawing engine: scans a sprite box, reads ROM pixels and plots them.
// Optional feature macro: SPRITE_TRANSPARENCY_EN (skip TRANSP_COLOUR pixels in CHAR mode).
module sprite_drawer
  import sprite_pkg::*;
#(
  parameter int                    SPRITE_W      = 8,
  parameter int                    SPRITE_H      = 8,
  parameter int                    COLOUR_W      = 9,
  parameter logic [COLOUR_W-1:0]   TRANSP_COLOUR = 9'h1FF
) (
  input  logic                                 clock,
  input  logic                                 resetn,
  input  logic                                 drawChar,
  input  logic                                 drawBG,
  input  logic [8:0]                           xIn,
  input  logic [7:0]                           yIn,
  output logic [$clog2(SPRITE_W*SPRITE_H)-1:0] spriteAddr,
  input  logic [COLOUR_W-1:0]                  spriteData,
  output logic [BG_ADDR_W-1:0]                 bgAddr,
  input  logic [COLOUR_W-1:0]                  bgData,
  output logic [8:0]                           vgaX,
  output logic [7:0]                           vgaY,
  output logic [COLOUR_W-1:0]                  vgaColour,
  output logic                                 vgaWrite,
  output logic                                 doneChar,
  output logic                                 doneBG,
  output logic [1:0]                           debugState
);

`ifdef SPRITE_TRANSPARENCY_EN
  localparam logic TRANSP_EN = 1'b1;
`else
  localparam logic TRANSP_EN = 1'b0;
`endif

  localparam int CX_W = $clog2(SPRITE_W);
  localparam int CY_W = $clog2(SPRITE_H);

  state_t            state, next_state;
  mode_t             mode;
  logic              pending;
  logic [8:0]        x_lat;
  logic [7:0]        y_lat;
  logic [CX_W-1:0]   cx;
  logic [CY_W-1:0]   cy;
  logic              last_pixel;
  logic              accept;

  // Requests are single-cycle strobes with no ready: they are taken only in IDLE
  // and dropped otherwise; a simultaneous BG+CHAR pair queues CHAR as pending.
  assign accept = (state == IDLE) && (drawBG || drawChar);

  sprite_scan_counter #(
    .SPRITE_W(SPRITE_W),
    .SPRITE_H(SPRITE_H)
  ) u_scan (
    .clock (clock),
    .resetn(resetn),
    .clear (accept || (state == DONE)),
    .enable(state == SCAN),
    .cx    (cx),
    .cy    (cy),
    .last  (last_pixel)
  );

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (drawBG || drawChar) next_state = SCAN;
      SCAN:    if (last_pixel) next_state = FLUSH;
      FLUSH:   next_state = DONE;
      DONE:    next_state = pending ? SCAN : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state   <= IDLE;
      mode    <= MODE_BG;
      pending <= 1'b0;
      x_lat   <= '0;
      y_lat   <= '0;
    end else begin
      state <= next_state;
      if (accept) begin
        x_lat   <= xIn;
        y_lat   <= yIn;
        mode    <= drawBG ? MODE_BG : MODE_CHAR;
        pending <= drawBG && drawChar;
      end else if ((state == DONE) && pending) begin
        mode    <= MODE_CHAR;  // reuse the latched coordinates for the queued character
        pending <= 1'b0;
      end
    end
  end

  // Screen-space pixel position and clipping
  logic [9:0] px;
  logic [8:0] py;
  logic       in_screen;

  assign px         = {1'b0, x_lat} + 10'(cx);
  assign py         = {1'b0, y_lat} + 9'(cy);
  assign in_screen  = (px < 10'(SCREEN_W)) && (py < 9'(SCREEN_H));
  assign spriteAddr = {cy, cx};
  assign bgAddr     = in_screen ? (BG_ADDR_W'(py) * BG_ADDR_W'(SCREEN_W) + BG_ADDR_W'(px))
                                : '0;

  // One-stage pipe aligns the plot coordinates with the ROM read latency
  logic                pipe_valid;
  logic [8:0]          pipe_x;
  logic [7:0]          pipe_y;
  logic [8:0]          hold_x;
  logic [7:0]          hold_y;
  logic [COLOUR_W-1:0] hold_colour;
  logic [COLOUR_W-1:0] pixel_colour;
  logic                plot;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      pipe_valid <= 1'b0;
      pipe_x     <= '0;
      pipe_y     <= '0;
    end else begin
      pipe_valid <= (state == SCAN) && in_screen;
      pipe_x     <= px[8:0];
      pipe_y     <= py[7:0];
    end
  end

  assign pixel_colour = (mode == MODE_CHAR) ? spriteData : bgData;
  assign plot = pipe_valid &&
                !(TRANSP_EN && (mode == MODE_CHAR) && (spriteData == TRANSP_COLOUR));

  always_ff @(posedge clock) begin
    if (!resetn) begin
      hold_x      <= '0;
      hold_y      <= '0;
      hold_colour <= '0;
    end else if (plot) begin
      hold_x      <= pipe_x;
      hold_y      <= pipe_y;
      hold_colour <= pixel_colour;
    end
  end

  assign vgaWrite   = plot;
  assign vgaX       = plot ? pipe_x : hold_x;
  assign vgaY       = plot ? pipe_y : hold_y;
  assign vgaColour  = plot ? pixel_colour : hold_colour;
  assign doneBG     = (state == DONE) && (mode == MODE_BG);
  assign doneChar   = (state == DONE) && (mode == MODE_CHAR);
  assign debugState = state;

endmodule

// File: tb/tb_sprite_drawer.sv
// Directed bench for sprite_drawer: per-cycle compare against a pixel-list model plus literal pins.
module tb_sprite_drawer;

  localparam int N        = 64;
  localparam int SW       = 8;
  localparam int DONE_LAT = N + 2;
  localparam int MAXC     = 4096;

`ifdef SPRITE_TRANSPARENCY_EN
  localparam bit TRANSP_MODEL = 1'b1;
`else
  localparam bit TRANSP_MODEL = 1'b0;
`endif

  logic        clock;
  logic        resetn;
  logic        drawChar, drawBG;
  logic [8:0]  xIn;
  logic [7:0]  yIn;
  logic [5:0]  spriteAddr;
  logic [8:0]  spriteData;
  logic [16:0] bgAddr;
  logic [8:0]  bgData;
  logic [8:0]  vgaX;
  logic [7:0]  vgaY;
  logic [8:0]  vgaColour;
  logic        vgaWrite, doneChar, doneBG;
  logic [1:0]  debugState;

  sprite_drawer dut (
    .clock(clock), .resetn(resetn), .drawChar(drawChar), .drawBG(drawBG),
    .xIn(xIn), .yIn(yIn), .spriteAddr(spriteAddr), .spriteData(spriteData),
    .bgAddr(bgAddr), .bgData(bgData), .vgaX(vgaX), .vgaY(vgaY),
    .vgaColour(vgaColour), .vgaWrite(vgaWrite), .doneChar(doneChar),
    .doneBG(doneBG), .debugState(debugState)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc;
  bit rst_q;
  always @(posedge clock) begin
    cyc   <= cyc + 1;
    rst_q <= !resetn;
  end

  // ---------------- ROM models ----------------
  logic [8:0] char_rom [N];

  function automatic logic [8:0] bg_pix(input int a);
    return 9'((a * 13 + 7) & 511);
  endfunction

  always @(posedge clock) begin
    spriteData <= char_rom[spriteAddr];
    bgData     <= bg_pix(int'(bgAddr));
  end

  // ---------------- model / scoreboard ----------------
  logic [25:0] exp_q[$];
  bit          exp_w [MAXC];
  bit          exp_av[MAXC];
  bit          exp_dc[MAXC];
  bit          exp_db[MAXC];
  int          exp_sa[MAXC];
  int          exp_ba[MAXC];

  int checks, errors;
  int wcount, dccount, dbcount;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Pixel k of the box sits at (x + k%W, y + k/W); address goes out one cycle after the
  // scan start, the plot one cycle later, and done after the whole box.
  task automatic schedule(input bit is_char, input int x, input int y, input int start);
    for (int k = 0; k < N; k++) begin
      int xx, yy, a;
      bit on;
      logic [8:0] col;
      xx = x + k % SW;
      yy = y + k / SW;
      a  = start + 1 + k;
      on = (xx < 320) && (yy < 240);
      exp_av[a] = 1'b1;
      exp_sa[a] = k;
      exp_ba[a] = on ? yy * 320 + xx : 0;
      col = is_char ? char_rom[k] : bg_pix(yy * 320 + xx);
      if (on && !(TRANSP_MODEL && is_char && col == 9'h1FF)) begin
        exp_w[a + 1] = 1'b1;
        exp_q.push_back({9'(xx), 8'(yy), col});
      end
    end
    if (is_char) exp_dc[start + DONE_LAT] = 1'b1;
    else         exp_db[start + DONE_LAT] = 1'b1;
  endtask

  // ---------------- compare process ----------------
  logic [25:0] last_plot;
  initial begin
    last_plot = '0;
    forever begin
      @(negedge clock);
      if (rst_q) last_plot = '0;
      chk("vgaWrite", 32'(vgaWrite), 32'(exp_w[cyc]));
      if (vgaWrite) begin
        wcount++;
        if (exp_q.size() == 0) begin
          chk("plot_unexpected", 32'({vgaX, vgaY, vgaColour}), 32'hFFFF_FFFF);
        end else begin
          last_plot = exp_q.pop_front();
          chk("plot_xyc", 32'({vgaX, vgaY, vgaColour}), 32'(last_plot));
        end
      end else begin
        chk("hold_xyc", 32'({vgaX, vgaY, vgaColour}), 32'(last_plot));
      end
      chk("doneChar", 32'(doneChar), 32'(exp_dc[cyc]));
      chk("doneBG", 32'(doneBG), 32'(exp_db[cyc]));
      if (doneChar) dccount++;
      if (doneBG)   dbcount++;
      if (exp_av[cyc]) begin
        chk("spriteAddr", 32'(spriteAddr), 32'(exp_sa[cyc]));
        chk("bgAddr", 32'(bgAddr), 32'(exp_ba[cyc]));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic request(input bit bg, input bit ch, input int x, input int y, output int t0);
    t0 = cyc;
    drawBG = bg; drawChar = ch; xIn = 9'(x); yIn = 8'(y);
    if (bg) schedule(1'b0, x, y, t0);
    if (ch) schedule(1'b1, x, y, bg ? t0 + DONE_LAT : t0);
    @(negedge clock);
    drawBG = 1'b0; drawChar = 1'b0;
  endtask

  task automatic clear_counts();
    wcount = 0; dccount = 0; dbcount = 0;
  endtask

  task automatic fill_rom(input bit all_transp);
    for (int i = 0; i < N; i++) char_rom[i] = all_transp ? 9'h1FF : 9'((i * 37 + 5) & 255);
  endtask

  // ---------------- stimulus ----------------
  int t0;
  initial begin
    resetn = 1'b0; drawChar = 1'b0; drawBG = 1'b0; xIn = '0; yIn = '0;
    fill_rom(1'b0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    resetn = 1'b1;

    // 1: idle after reset
    repeat (10) begin
      @(negedge clock);
      chk("idle_zero", 32'({spriteAddr, bgAddr, vgaX, vgaY, vgaColour, vgaWrite, doneChar, doneBG}), 32'd0);
      chk("idle_state", 32'(debugState), 32'd0);
    end

    // 2: character at (1,16)
    clear_counts();
    request(1'b0, 1'b1, 1, 16, t0);
    chk("t2_first_addr", 32'(spriteAddr), 32'd0);
    @(negedge clock);
    chk("t2_first_write", 32'({vgaWrite, vgaX, vgaY}), 32'({1'b1, 9'd1, 8'd16}));
    repeat (63) @(negedge clock);
    chk("t2_last_write", 32'({vgaWrite, vgaX, vgaY}), 32'({1'b1, 9'd8, 8'd23}));
    @(negedge clock);
    chk("t2_done_cycle", 32'(cyc - t0), 32'd66);
    chk("t2_doneChar", 32'(doneChar), 32'd1);
    repeat (4) @(negedge clock);
    chk("t2_writes", 32'(wcount), 32'd64);
    chk("t2_done_count", 32'(dccount), 32'd1);

    // 3: background at (10,20)
    clear_counts();
    request(1'b1, 1'b0, 10, 20, t0);
    chk("t3_first_bgAddr", 32'(bgAddr), 32'd6410);
    repeat (65) @(negedge clock);
    chk("t3_doneBG", 32'(doneBG), 32'd1);
    repeat (4) @(negedge clock);
    chk("t3_writes", 32'(wcount), 32'd64);
    chk("t3_no_doneChar", 32'(dccount), 32'd0);

    // 4: clipped at the bottom-right corner
    clear_counts();
    request(1'b0, 1'b1, 316, 236, t0);
    repeat (65) @(negedge clock);
    chk("t4_doneChar", 32'(doneChar), 32'd1);
    repeat (4) @(negedge clock);
    chk("t4_writes", 32'(wcount), 32'd16);

    // 5: simultaneous BG + CHAR
    clear_counts();
    request(1'b1, 1'b1, 40, 40, t0);
    repeat (65) @(negedge clock);
    chk("t5_doneBG", 32'(doneBG), 32'd1);
    chk("t5_writes_bg", 32'(wcount), 32'd64);
    repeat (66) @(negedge clock);
    chk("t5_doneChar", 32'(doneChar), 32'd1);
    repeat (4) @(negedge clock);
    chk("t5_writes", 32'(wcount), 32'd128);
    chk("t5_dones", 32'({dbcount[7:0], dccount[7:0]}), 32'h0101);

    // 6: fully transparent sprite
    fill_rom(1'b1);
    clear_counts();
    request(1'b0, 1'b1, 100, 50, t0);
    repeat (65) @(negedge clock);
    chk("t6_doneChar", 32'(doneChar), 32'd1);
    repeat (4) @(negedge clock);
    chk("t6_writes", 32'(wcount), TRANSP_MODEL ? 32'd0 : 32'd64);
    fill_rom(1'b0);

    // 7: reset in the middle of a character draw
    request(1'b0, 1'b1, 50, 60, t0);
    repeat (29) @(negedge clock);
    resetn = 1'b0;
    for (int i = cyc + 1; i < MAXC; i++) begin
      exp_w[i] = 1'b0; exp_av[i] = 1'b0; exp_dc[i] = 1'b0; exp_db[i] = 1'b0;
    end
    exp_q.delete();
    @(negedge clock);
    resetn = 1'b1;
    clear_counts();
    chk("t7_state_reset", 32'(debugState), 32'd0);
    repeat (50) @(negedge clock);
    chk("t7_writes", 32'(wcount), 32'd0);
    chk("t7_no_done", 32'(dccount), 32'd0);
    chk("t7_state_idle", 32'(debugState), 32'd0);
    chk("t7_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
